// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions for the x^16+x^14+x^13+x^11+1 word stream.
// Used by the checker and available to the generator side.
package lfsr_pkg;

    localparam int unsigned LFSR_W = 16;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    typedef logic [LFSR_W-1:0] word_t;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    // Fibonacci step: shift left, feedback is parity of the tapped bits.
    function automatic word_t step(input word_t d);
        return {d[LFSR_W-2:0], ^(d & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/lfsr_checker_if.sv
// Word-stream input and status output bundle for lfsr_checker.
// The master side is the generator/link plus the status consumer.
interface lfsr_checker_if #(
    parameter int unsigned ERR_W = 16
);
    import lfsr_pkg::*;

    logic             in_valid;
    word_t            in_data;
    logic             clear;
    logic             locked;
    logic             err_pulse;
    logic [ERR_W-1:0] err_count;
    word_t            expected;
    logic [31:0]      word_count;

    modport master (
        output in_valid, in_data, clear,
        input  locked, err_pulse, err_count, expected, word_count
    );

    modport slave (
        input  in_valid, in_data, clear,
        output locked, err_pulse, err_count, expected, word_count
    );

endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; clr wins over a same-cycle inc.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/lfsr_checker.sv
// Self-synchronising checker for the 16-bit LFSR word stream.
// Optional locked-word statistics counter: define LFSR_CHK_STATS_EN.
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int unsigned LOCK_COUNT = 4,
    parameter int unsigned LOSS_COUNT = 3,
    parameter int unsigned ERR_W      = 16
) (
    input  logic           clk,
    input  logic           rst,
    lfsr_checker_if.slave  bus
);

    localparam int unsigned MATCH_W = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT + 1) : 1;
    localparam int unsigned MISS_W  = (LOSS_COUNT > 1) ? $clog2(LOSS_COUNT + 1) : 1;

    state_t             state;
    word_t              expected_q;
    logic [MATCH_W-1:0] match_cnt;
    logic [MISS_W-1:0]  miss_cnt;
    logic               locked_q;
    logic               err_pulse_q;
    logic               is_match_c;
    logic               err_inc_c;

    assign is_match_c = (bus.in_data == expected_q);
    assign err_inc_c  = bus.in_valid && (state == LOCKED) && !is_match_c;

    // Hunt / verify / locked sequencing with registered status outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= HUNT;
            expected_q  <= '0;
            match_cnt   <= '0;
            miss_cnt    <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
        end else begin
            err_pulse_q <= 1'b0;
            if (bus.in_valid) begin
                case (state)
                    HUNT: begin
                        if (bus.in_data != '0) begin
                            expected_q <= step(bus.in_data);
                            match_cnt  <= '0;
                            state      <= VERIFY;
                        end
                    end
                    VERIFY: begin
                        if (is_match_c) begin
                            expected_q <= step(expected_q);
                            if (match_cnt == MATCH_W'(LOCK_COUNT - 1)) begin
                                state    <= LOCKED;
                                locked_q <= 1'b1;
                                miss_cnt <= '0;
                                match_cnt <= '0;
                            end else begin
                                match_cnt <= match_cnt + MATCH_W'(1);
                            end
                        end else if (bus.in_data != '0) begin
                            expected_q <= step(bus.in_data);
                            match_cnt  <= '0;
                        end else begin
                            state <= HUNT;
                        end
                    end
                    LOCKED: begin
                        expected_q <= step(expected_q);
                        if (is_match_c) begin
                            miss_cnt <= '0;
                        end else begin
                            err_pulse_q <= 1'b1;
                            if (miss_cnt == MISS_W'(LOSS_COUNT - 1)) begin
                                state    <= HUNT;
                                locked_q <= 1'b0;
                                miss_cnt <= '0;
                            end else begin
                                miss_cnt <= miss_cnt + MISS_W'(1);
                            end
                        end
                    end
                    default: begin
                        state    <= HUNT;
                        locked_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    sat_counter #(
        .W (ERR_W)
    ) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (err_inc_c),
        .clr   (bus.clear),
        .count (bus.err_count)
    );

`ifdef LFSR_CHK_STATS_EN
    logic [31:0] word_cnt_q;

    // Every valid word seen while locked, good or bad; wraps naturally.
    always_ff @(posedge clk) begin
        if (!rst) begin
            word_cnt_q <= '0;
        end else if (bus.clear) begin
            word_cnt_q <= '0;
        end else if (bus.in_valid && (state == LOCKED)) begin
            word_cnt_q <= word_cnt_q + 32'(1);
        end
    end

    assign bus.word_count = word_cnt_q;
`else
    assign bus.word_count = '0;
`endif

    assign bus.locked    = locked_q;
    assign bus.err_pulse = err_pulse_q;
    assign bus.expected  = expected_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Bench for lfsr_checker: directed vector table, hand sequences, and
// randomized stream against a sequence-level reference model.
module tb_lfsr_checker;

    localparam int unsigned LOCK  = 4;
    localparam int unsigned LOSS  = 3;
    localparam int unsigned EW    = 4;
    localparam int unsigned EMAX  = (1 << EW) - 1;
`ifdef LFSR_CHK_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct {
        bit          r;
        bit          v;
        logic [15:0] d;
        bit          c;
        bit          e_locked;
        bit          e_pulse;
        logic [EW-1:0] e_err;
        logic [15:0] e_exp;
        logic [31:0] e_wc;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    vec_t tbl[$];

    lfsr_checker_if #(.ERR_W(EW)) bus ();

    lfsr_checker #(
        .LOCK_COUNT (LOCK),
        .LOSS_COUNT (LOSS),
        .ERR_W      (EW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] rs(input logic [15:0] d);
        return {d[14:0], d[15] ^ d[13] ^ d[12] ^ d[10]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic cmp_all(input string tag, input bit el, input bit ep,
                           input logic [EW-1:0] ee, input logic [15:0] ex,
                           input logic [31:0] ewc);
        chk({tag, ".locked"},     32'(bus.locked),     32'(el));
        chk({tag, ".err_pulse"},  32'(bus.err_pulse),  32'(ep));
        chk({tag, ".err_count"},  32'(bus.err_count),  32'(ee));
        chk({tag, ".expected"},   32'(bus.expected),   32'(ex));
        chk({tag, ".word_count"}, bus.word_count,      ewc);
    endtask

    task automatic drive(input bit r, input bit v, input logic [15:0] d, input bit c);
        rst          = r;
        bus.in_valid = v;
        bus.in_data  = d;
        bus.clear    = c;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input bit r, input bit v, input logic [15:0] d, input bit c,
                       input bit el, input bit ep, input int unsigned ee,
                       input logic [15:0] ex, input int unsigned wc);
        vec_t t;
        t.r = r; t.v = v; t.d = d; t.c = c;
        t.e_locked = el; t.e_pulse = ep; t.e_err = EW'(ee);
        t.e_exp = ex; t.e_wc = STATS ? 32'(wc) : 32'd0;
        tbl.push_back(t);
    endtask

    // Reference model: tracks sync as a run of words each the step of the last.
    bit          m_have, m_locked, m_pulse;
    int unsigned m_run, m_miss, m_err;
    logic [15:0] m_exp;
    logic [31:0] m_wc;

    task automatic model(input bit r, input bit v, input logic [15:0] d, input bit c);
        bit inc;
        inc = 1'b0;
        if (!r) begin
            m_have = 0; m_locked = 0; m_pulse = 0; m_run = 0; m_miss = 0;
            m_err = 0; m_exp = '0; m_wc = '0;
            return;
        end
        m_pulse = 1'b0;
        if (v) begin
            if (m_locked) begin
                if (STATS) m_wc = m_wc + 32'd1;
                if (d != m_exp) begin
                    m_pulse = 1'b1;
                    inc = 1'b1;
                    m_miss++;
                    if (m_miss == LOSS) begin
                        m_locked = 0; m_have = 0; m_miss = 0;
                    end
                end else begin
                    m_miss = 0;
                end
                m_exp = rs(m_exp);
            end else if (m_have && d == m_exp) begin
                m_run++;
                m_exp = rs(m_exp);
                if (m_run == LOCK) begin
                    m_locked = 1; m_miss = 0;
                end
            end else if (d != 16'd0) begin
                m_have = 1; m_run = 0; m_exp = rs(d);
            end else begin
                m_have = 0;
            end
        end
        if (c) begin
            m_err = 0; m_wc = '0;
        end else if (inc && m_err < EMAX) begin
            m_err++;
        end
    endtask

    initial begin
        logic [15:0] w, s, d, g;
        int unsigned burst;
        bit r, v, c;
        int unsigned roll;

        rst = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0; bus.clear = 1'b0;

        // Directed table: lock, single error, loss of lock, relock, clear, reset.
        w = 16'hACE1;
        add(0, 0, 16'h0, 0, 0, 0, 0, 16'h0, 0);
        for (int i = 0; i < 10; i++) begin
            add(1, 1, w, 0, i >= 4, 0, 0, (i == 0) ? 16'h59C3 : rs(w),
                (i >= 5) ? 32'(i - 4) : 0);
            w = rs(w);
        end
        add(1, 1, w ^ 16'h1, 0, 1, 1, 1, rs(w), 6);  w = rs(w);
        add(1, 1, w,         0, 1, 0, 1, rs(w), 7);  w = rs(w);
        add(1, 1, w ^ 16'h1, 0, 1, 1, 2, rs(w), 8);  w = rs(w);
        add(1, 1, w ^ 16'h1, 0, 1, 1, 3, rs(w), 9);  w = rs(w);
        add(1, 1, w,         0, 1, 0, 3, rs(w), 10); w = rs(w);
        for (int k = 0; k < 3; k++) begin
            add(1, 1, w ^ 16'h1, 0, k < 2, 1, 32'(4 + k), rs(w), 32'(11 + k));
            w = rs(w);
        end
        add(1, 0, 16'hFFFF, 0, 0, 0, 6, w, 13);
        for (int i = 0; i < 5; i++) begin
            add(1, 1, w, 0, i == 4, 0, 6, rs(w), 13);
            w = rs(w);
        end
        add(1, 1, w,         0, 1, 0, 6, rs(w), 14); w = rs(w);
        add(1, 1, w ^ 16'h1, 1, 1, 1, 0, rs(w), 0);  w = rs(w);
        add(1, 1, w,         0, 1, 0, 0, rs(w), 1);  w = rs(w);
        add(0, 1, w,         0, 0, 0, 0, 16'h0, 0);
        for (int i = 0; i < 3; i++) add(1, 1, 16'h0, 0, 0, 0, 0, 16'h0, 0);
        // Reseed in VERIFY, then a zero word must drop back to HUNT.
        add(1, 1, 16'h1234, 0, 0, 0, 0, rs(16'h1234), 0);
        add(1, 1, 16'h5555, 0, 0, 0, 0, rs(16'h5555), 0);
        add(1, 1, 16'h0000, 0, 0, 0, 0, rs(16'h5555), 0);
        s = rs(16'h5555);
        for (int i = 0; i < 5; i++) begin
            add(1, 1, s, 0, i == 4, 0, 0, rs(s), 0);
            s = rs(s);
        end

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].r, tbl[i].v, tbl[i].d, tbl[i].c);
            cmp_all($sformatf("vec%0d", i), tbl[i].e_locked, tbl[i].e_pulse,
                    tbl[i].e_err, tbl[i].e_exp, tbl[i].e_wc);
        end

        // Reset mid-lock with two errors and eight locked words behind it.
        drive(0, 0, 16'h0, 0);
        w = 16'hACE1;
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, w, 0);
            w = rs(w);
        end
        for (int i = 0; i < 8; i++) begin
            drive(1, 1, (i == 2 || i == 5) ? (w ^ 16'h8000) : w, 0);
            w = rs(w);
        end
        cmp_all("prerst", 1, 0, 2, w, STATS ? 32'd8 : 32'd0);
        drive(0, 1, w, 0);
        cmp_all("postrst", 0, 0, 0, 16'h0, 32'd0);

        // Randomized stream with corruption, bursts, zeros, jumps, clears, resets.
        model(0, 0, 16'h0, 0);
        drive(0, 0, 16'h0, 0);
        g = 16'(($urandom % 65535) + 1);
        burst = 0;
        for (int n = 0; n < 4000; n++) begin
            r = ($urandom % 700) != 0;
            v = ($urandom % 4) != 0;
            c = ($urandom % 500) == 0;
            d = 16'h0;
            if (v) begin
                roll = $urandom % 200;
                g = rs(g);
                d = g;
                if (roll < 2) begin
                    g = 16'(($urandom % 65535) + 1);
                    d = g;
                end else if (roll < 5) begin
                    d = 16'h0;
                end else if (roll < 16 || burst > 0) begin
                    d = g ^ (16'h1 << ($urandom % 16));
                    if (burst > 0) burst--;
                end
                if (roll >= 196) burst = 3;
            end
            drive(r, v, d, c);
            model(r, v, d, c);
            cmp_all($sformatf("rnd%0d", n), m_locked, m_pulse, EW'(m_err), m_exp, m_wc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lfsr_checker.md
# lfsr_checker

- Receiving end of the 16-bit pseudo-random word stream produced by the lab's random-word generator.
- Self-synchronises a local LFSR to the incoming words, declares lock, then checks every subsequent word.
- Counts mismatches and drops lock after sustained errors.
- Sits between the generator (or a link carrying its words) and the board display / status LEDs.

## Interface

Parameters:
- LOCK_COUNT, 4: consecutive predicted matches required to enter LOCKED (≥1).
- LOSS_COUNT, 3: consecutive mismatches in LOCKED that force a return to HUNT (≥1).
- ERR_W, 16: width of the error counter.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  synchronous, active-low reset.
- in_valid  input  1  in_data is a new word this cycle.
- in_data  input  16  received word.
- clear  input  1  synchronous clear of err_count (and word_count when compiled in).
- locked  output  1  high while in LOCKED.
- err_pulse  output  1  one-cycle pulse per mismatched word in LOCKED.
- err_count  output  ERR_W  saturating count of mismatches in LOCKED.
- expected  output  16  next predicted word.
- word_count  output  32  words received while LOCKED (see Configuration).

## Operation

- Polynomial x^16+x^14+x^13+x^11+1, Fibonacci form.
- step(d) = {d[14:0], d[15]^d[13]^d[12]^d[10]}.
- Each valid word is step() of the previous word.
- Words with in_valid low are ignored; all state holds.

States:
- HUNT (reset state), on valid word:
  - in_data == 0: ignored (lock-up value); stay in HUNT.
  - otherwise: expected ← step(in_data), match_cnt ← 0, go to VERIFY.
- VERIFY, on valid word:
  - in_data == expected: match_cnt++, expected ← step(expected).
  - If match_cnt reaches LOCK_COUNT on that word, go to LOCKED and set miss_cnt ← 0.
  - Mismatch with nonzero in_data: reseed, expected ← step(in_data), match_cnt ← 0.
  - Mismatch with zero in_data: go to HUNT.
  - No errors are counted in VERIFY.
- LOCKED, on valid word:
  - expected ← step(expected) always; no reseeding from data.
  - Match: miss_cnt ← 0.
  - Mismatch: err_pulse, err_count saturating increment, miss_cnt++.
  - If miss_cnt reaches LOSS_COUNT, go to HUNT.

Counters and clear:
- err_count saturates at all-ones; it is not cleared by lock loss.
- clear has priority over a same-cycle increment: the counter becomes 0 and that error is not counted. err_pulse still fires.

## Timing

- Outputs are registered. Response appears the cycle after the in_valid edge that caused it.
- locked rises the cycle after the LOCK_COUNT-th matching word in VERIFY.
- Minimum lock time: 1 + LOCK_COUNT valid words.
- locked falls the cycle after the LOSS_COUNT-th consecutive mismatch.
- err_pulse is high for exactly one cycle per erroneous word. Back-to-back errors give back-to-back pulses.
- expected updates the cycle after each accepted word.
- Reset values: locked=0, err_pulse=0, err_count=0, expected=0, word_count=0, state=HUNT, match_cnt=0, miss_cnt=0.
- Reset asserted mid-lock returns everything to reset values on the next edge.

## Configuration

- LFSR_CHK_STATS_EN defined:
  - 32-bit word_count increments on every valid word accepted in LOCKED, matched or not.
  - Wraps at 2^32.
  - Cleared by clear and rst.
- Not defined:
  - word_count is tied to 0 and no counter register exists.
  - All other behaviour is identical.

## Structure

- Package lfsr_pkg holds:
  - state enum typedef (HUNT, VERIFY, LOCKED);
  - LFSR_W = 16;
  - polynomial tap constant 16'hB400;
  - step() as a function, so the generator side can share it.
- One sub-module: sat_counter (parameterised width, inc, clr, saturate), used for err_count.

## Test plan

- Seed 16'hACE1, then clean stream of 10 words (first predicted 16'h59C3): locked rises after word 5; err_count=0; expected tracks.
- Locked, corrupt one word (flip bit 0): one err_pulse, err_count=1, locked stays 1. Next clean word gives miss_cnt=0.
- Locked, 3 consecutive corrupt words: err_count=3; locked falls after the third. A subsequent clean stream relocks after 5 words and err_count stays 3.
- Stream of 16'h0000 words from reset: stays in HUNT, locked=0, err_count=0.
- clear asserted in the same cycle as a LOCKED mismatch: err_count=0, err_pulse=1.
- rst low mid-lock with err_count=2: all outputs 0 next cycle. With LFSR_CHK_STATS_EN, word_count after 8 locked words is 8 before the reset and 0 after it.
